// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter; req_op carries the raw 4-bit alu_op_t
// encoding so the interface stays free of package dependencies.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0][3:0]  req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_res;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res
  );
endinterface

// File: rtl/alu_arbiter.sv
// One shared alu among NREQ requesters, round-robin or lowest-index-first with ALU_ARB_FIXED_PRIO_EN.
// Result registered one cycle after accept; every req_ready drops while a held response is stalled.

package risc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module alu
  import risc_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res
);
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'b0, a < b};
      default:  res = '0;
    endcase
  end
endmodule

module alu_arbiter
  import risc_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  logic           can_issue;
  logic           gnt_vld;
  logic           issue;
  logic [IDW-1:0] gnt_idx;
  logic [31:0]    alu_res;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0] ptr;
  logic [SW-1:0]  scan;
`endif

  // Grant depends only on req_valid and ptr, never on operand payloads.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
`else
    scan = '0;
    // Walk the rotated order backwards so the candidate closest to ptr is written last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = {1'b0, ptr} + SW'(i);
      if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
      if (bus.req_valid[scan[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[IDW-1:0];
      end
    end
`endif
  end

  assign can_issue = !bus.rsp_valid || bus.rsp_ready;
  assign issue     = gnt_vld && can_issue && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (issue) bus.req_ready[gnt_idx] = 1'b1;
  end

  alu u_alu (
    .op  (alu_op_t'(bus.req_op[gnt_idx])),
    .a   (bus.req_a[gnt_idx]),
    .b   (bus.req_b[gnt_idx]),
    .res (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_res   <= '0;
      bus.rsp_id    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr           <= '0;
`endif
    end else if (issue) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_res   <= alu_res;
      bus.rsp_id    <= gnt_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr           <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`endif
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter against a queue-free behavioural model.
module tb_alu_arbiter;
  import risc_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();
  alu_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return sa >>> sh;
      4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Model: buffer contents plus the index the rotation starts from next.
  int          m_ptr   = 0;
  logic        m_vld   = 1'b0;
  logic [31:0] m_res   = '0;
  int          m_id    = 0;
  bit          m_known = 1'b0;

  initial begin : model_check
    int g, start;
    logic [NREQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      start = m_ptr;
`ifdef ALU_ARB_FIXED_PRIO_EN
      start = 0;
`endif
      g = -1;
      if (!rst && !(m_vld && !bus.rsp_ready)) begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req_valid[(start + k) % NREQ]) g = (start + k) % NREQ;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (m_known) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
        chk("rsp_id", 32'(bus.rsp_id), m_id);
        chk("rsp_res", bus.rsp_res, m_res);
      end
      if (rst) begin
        m_vld = 1'b0; m_res = '0; m_id = 0; m_ptr = 0; m_known = 1'b1;
      end else if (g >= 0) begin
        m_res = ref_alu(bus.req_op[g], bus.req_a[g], bus.req_b[g]);
        m_id  = g;
        m_vld = 1'b1;
        m_ptr = (g + 1) % NREQ;
      end else if (m_vld && bus.rsp_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op[i] = op;
    bus.req_a[i]  = a;
    bus.req_b[i]  = b;
  endtask

  initial begin : stim
    logic [NREQ-1:0] acc;
    int gexp [4];
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    gexp = '{0, 0, 0, 0};
`else
    gexp = '{0, 1, 0, 1};
`endif
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_res", bus.rsp_res, 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

    // Single SUB request
    step();
    set_req(0, ALU_SUB, 32'd5, 32'd3);
    bus.req_valid = 3'b001;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    chk("single_res", bus.rsp_res, 32'd2);

    // Round-robin between two held requesters
    step(); rst = 1'b1; step(); rst = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_XOR, 32'd3, 32'd5);
    bus.req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << gexp[k]));
      if (k > 0) chk("rr_rsp_id", 32'(bus.rsp_id), 32'(gexp[k-1]));
      step();
    end

    // Back-pressure on an SRA result, then drain and issue together
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd31);
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("bp_issue_ready", 32'(bus.req_ready), 32'd1);
    step();
    set_req(1, ALU_ADD, 32'd7, 32'd8);
    bus.req_valid = 3'b010;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_stall_res", bus.rsp_res, 32'hFFFF_FFFF);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_issue", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_next_id", 32'(bus.rsp_id), 32'd1);
    chk("bp_next_res", bus.rsp_res, 32'd15);

    // Signed vs unsigned compare, tagged per requester
    step(); rst = 1'b1; step(); rst = 1'b0;
    set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk("cmp_ready0", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 3'b010;
    @(negedge clk);
    chk("cmp_ready1", 32'(bus.req_ready), 32'd2);
    chk("slt_id", 32'(bus.rsp_id), 32'd0);
    chk("slt_res", bus.rsp_res, 32'd1);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("sltu_valid", 32'(bus.rsp_valid), 32'd1);
    chk("sltu_id", 32'(bus.rsp_id), 32'd1);
    chk("sltu_res", bus.rsp_res, 32'd0);

    // Wrap from the last index, then reset with a response pending
    step(); rst = 1'b1; step(); rst = 1'b0;
    set_req(2, ALU_ADD, 32'd10, 32'd20);
    bus.req_valid = 3'b100;
    @(negedge clk);
    chk("wrap_ready", 32'(bus.req_ready), 32'd4);
    step();
    bus.req_valid = 3'b111;
    @(negedge clk);
    chk("wrap_ptr_ready", 32'(bus.req_ready), 32'd1);
    chk("wrap_id", 32'(bus.rsp_id), 32'd2);
    chk("wrap_res", bus.rsp_res, 32'd30);
    step();
    rst           = 1'b1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_cycle_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_cycle_pending", 32'(bus.rsp_valid), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_res", bus.rsp_res, 32'd0);
    chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = '0;

    // Random traffic; requesters hold valid and payload until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      step();
      rst           = ($urandom_range(0, 199) == 0);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_op[i]    = 4'($urandom_range(0, 15));
          bus.req_a[i]     = rnd_word();
          bus.req_b[i]     = rnd_word();
        end
      end
    end
    rst = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
